nixie_scan_ctrl: RTL and testbench

Parametrised multiplexed 7-segment display controller for N_DIG digits.
- Holds a writable per-digit register file (BCD value plus decimal point).
- Time-multiplexes the digits at a programmable scan rate.
- Adds 16-level brightness PWM, per-digit blink, leading-zero suppression and an anti-ghosting guard cycle.
- Sits between the datapath (counters, clocks, meters) and the board's LED_Bit/LED_SEG pins.

---
 rtl/nixie_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_nixie_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nixie_scan_ctrl.sv
// nixie_scan_ctrl: multiplexed 7-segment scanner with a per-digit register
// file, 16-level PWM brightness, blink, leading-zero suppression and guard cycle.
module nixie_scan_ctrl #(
    parameter int N_DIG       = 8,
    parameter int CLK_DIV     = 125000,
    parameter int BLINK_DIV   = 200,
    parameter bit BIT_ACT_LOW = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b0,
    localparam int AW         = $clog2(N_DIG)
) (
    input  logic             cp,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [3:0]       wr_data,
    input  logic             wr_dp,
    input  logic             disp_en,
    input  logic             lzs_en,
    input  logic [3:0]       bright,
    input  logic [N_DIG-1:0] blink_mask,
    output logic [N_DIG-1:0] LED_Bit,
    output logic [7:0]       LED_SEG,
    output logic [AW-1:0]    scan_idx
);
    localparam int PH_LEN = CLK_DIV / 16;
    localparam int PW     = $clog2(PH_LEN);
    localparam int BW     = $clog2(BLINK_DIV + 1);

    localparam logic [N_DIG-1:0] BIT_OFF = {N_DIG{BIT_ACT_LOW}};
    localparam logic [7:0]       SEG_OFF = {8{SEG_ACT_LOW}};

    logic [PW-1:0] ph_cnt;
    logic [3:0]    phase;
    logic [AW-1:0] dig;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    logic ph_wrap;
    logic slot_wrap;
    logic dig_last;
    logic blink_wrap;

    logic [3:0] val_q [N_DIG];
    logic       dp_q  [N_DIG];

    logic [N_DIG-1:0] dig_sel;
    logic [3:0]       cur_val;
    logic             cur_dp;
    logic             lz_blank;
    logic             bl_blank;
    logic             guard;
    logic             dig_on;
    logic [6:0]       glyph;
    logic [7:0]       seg_nxt;
    logic [N_DIG-1:0] bit_nxt;

    assign ph_wrap    = (ph_cnt == PW'(PH_LEN - 1));
    assign slot_wrap  = ph_wrap && (phase == 4'd15);
    assign dig_last   = (dig == AW'(N_DIG - 1));
    assign blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));

    always_ff @(posedge cp) begin
        if (rst) begin
            ph_cnt      <= '0;
            phase       <= 4'd0;
            dig         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            ph_cnt <= ph_wrap ? '0 : ph_cnt + 1'b1;
            if (ph_wrap) begin
                phase <= phase + 4'd1;
            end
            if (slot_wrap) begin
                dig <= dig_last ? '0 : dig + 1'b1;
                if (blink_wrap) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Addresses at or above N_DIG never match a slot, so they are dropped.
    always_ff @(posedge cp) begin
        if (rst) begin
            for (int i = 0; i < N_DIG; i++) begin
                val_q[i] <= 4'd0;
                dp_q[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_DIG; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    val_q[i] <= wr_data;
                    dp_q[i]  <= wr_dp;
                end
            end
        end
    end

    always_comb begin
        dig_sel = '0;
        cur_val = 4'd0;
        cur_dp  = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            if (dig == AW'(i)) begin
                dig_sel[i] = 1'b1;
                cur_val    = val_q[i];
                cur_dp     = dp_q[i];
            end
        end
    end

    // Digit is a leading zero when it and every more significant digit are 0.
    always_comb begin
        lz_blank = lzs_en && (dig != '0);
        for (int i = 0; i < N_DIG; i++) begin
            if ((AW'(i) >= dig) && (val_q[i] != 4'd0)) begin
                lz_blank = 1'b0;
            end
        end
    end

    always_comb begin
        glyph = 7'h00;
        unique case (cur_val)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            4'd10:   glyph = 7'h40;
            default: glyph = 7'h00;
        endcase
    end

    assign bl_blank = blink_phase && (|(blink_mask & dig_sel));
    assign guard    = (phase == 4'd0) && (ph_cnt == '0);
    assign dig_on   = disp_en && (phase <= bright) && !guard;
    assign bit_nxt  = dig_on ? dig_sel : '0;

    always_comb begin
        seg_nxt = {cur_dp, glyph};
        if (lz_blank) begin
            seg_nxt[6:0] = 7'h00;
        end
        if (bl_blank || !dig_on) begin
            seg_nxt = 8'h00;
        end
    end

    always_ff @(posedge cp) begin
        if (rst) begin
            LED_Bit  <= BIT_OFF;
            LED_SEG  <= SEG_OFF;
            scan_idx <= '0;
        end else begin
            LED_Bit  <= bit_nxt ^ BIT_OFF;
            LED_SEG  <= seg_nxt ^ SEG_OFF;
            scan_idx <= dig;
        end
    end

endmodule

// File: tb/tb_nixie_scan_ctrl.sv
// Directed bench for nixie_scan_ctrl: 4-digit main instance plus a
// 5-digit instance for out-of-range write addresses.
module tb_nixie_scan_ctrl;
    logic       cp = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [3:0] wr_data = 4'd0;
    logic       wr_dp = 1'b0;
    logic       disp_en = 1'b0;
    logic       lzs_en = 1'b0;
    logic [3:0] bright = 4'd0;
    logic [3:0] blink_mask = 4'd0;
    logic [3:0] led_bit;
    logic [7:0] led_seg;
    logic [1:0] scan_idx;

    logic       wr_en5 = 1'b0;
    logic [2:0] wr_addr5 = 3'd0;
    logic [3:0] wr_data5 = 4'd0;
    logic       wr_dp5 = 1'b0;
    logic [4:0] blink_mask5 = 5'd0;
    logic [4:0] led_bit5;
    logic [7:0] led_seg5;
    logic [2:0] scan_idx5;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int exp_on = 31;
    bit chk5 = 1'b0;
    logic [7:0] exp_seg [4];

    logic [3:0] cap_bits;
    logic [7:0] cap_seg;
    int         cap_on;
    int         cap_bad;
    logic       cap_gd;
    logic [1:0] cap_idx;
    logic [4:0] cap_bits5;
    logic [7:0] cap_seg5;
    logic [2:0] cap_idx5;

    nixie_scan_ctrl #(
        .N_DIG(4), .CLK_DIV(32), .BLINK_DIV(2),
        .BIT_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b0)
    ) u_dut (
        .cp(cp), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dp(wr_dp), .disp_en(disp_en),
        .lzs_en(lzs_en), .bright(bright), .blink_mask(blink_mask),
        .LED_Bit(led_bit), .LED_SEG(led_seg), .scan_idx(scan_idx)
    );

    nixie_scan_ctrl #(
        .N_DIG(5), .CLK_DIV(32), .BLINK_DIV(2),
        .BIT_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b0)
    ) u_dut5 (
        .cp(cp), .rst(rst), .wr_en(wr_en5), .wr_addr(wr_addr5),
        .wr_data(wr_data5), .wr_dp(wr_dp5), .disp_en(disp_en),
        .lzs_en(lzs_en), .bright(bright), .blink_mask(blink_mask5),
        .LED_Bit(led_bit5), .LED_SEG(led_seg5), .scan_idx(scan_idx5)
    );

    always #5 cp = ~cp;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge cp);
        #1;
        cyc++;
    endtask

    task automatic align();
        while (cyc % 32 != 0) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d,
                      input logic p);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_dp = p;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wr5(input logic [2:0] a, input logic [3:0] d);
        wr_en5 = 1'b1;
        wr_addr5 = a;
        wr_data5 = d;
        wr_dp5 = 1'b0;
        tick();
        wr_en5 = 1'b0;
    endtask

    task automatic run_slot();
        cap_bits = 4'hF;
        cap_seg = 8'h00;
        cap_on = 0;
        cap_bad = 0;
        cap_gd = 1'b0;
        cap_idx = 2'd0;
        cap_bits5 = 5'h1F;
        cap_seg5 = 8'h00;
        cap_idx5 = 3'd0;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (k == 0) cap_gd = (led_bit == 4'hF) && (led_seg == 8'h00);
            if (led_bit != 4'hF) begin
                cap_on++;
                cap_bits = led_bit;
                cap_seg = led_seg;
            end else if (led_seg != 8'h00) begin
                cap_bad++;
            end
            if ($countones(~led_bit) > 1) cap_bad++;
            if (led_bit5 != 5'h1F) begin
                cap_bits5 = led_bit5;
                cap_seg5 = led_seg5;
            end
            if (k == 31) begin
                cap_idx = scan_idx;
                cap_idx5 = scan_idx5;
            end
        end
    endtask

    task automatic slot_chk(input string tag);
        int s;
        int d;
        int d5;
        logic [3:0] eb;
        logic [4:0] eb5;
        logic [7:0] es;
        s = cyc / 32;
        d = s % 4;
        d5 = s % 5;
        eb = 4'hF;
        es = 8'h00;
        if (exp_on > 0) begin
            eb[d] = 1'b0;
            es = exp_seg[d];
        end
        run_slot();
        check($sformatf("%s_bits_s%0d", tag, s), cap_bits, eb);
        check($sformatf("%s_seg_s%0d", tag, s), cap_seg, es);
        check($sformatf("%s_on_s%0d", tag, s), cap_on, exp_on);
        check($sformatf("%s_guard_s%0d", tag, s), cap_gd, 1);
        check($sformatf("%s_idx_s%0d", tag, s), cap_idx, d);
        check($sformatf("%s_dark_s%0d", tag, s), cap_bad, 0);
        if (chk5) begin
            eb5 = 5'h1F;
            eb5[d5] = 1'b0;
            check($sformatf("%s_bits5_s%0d", tag, s), cap_bits5, eb5);
            check($sformatf("%s_seg5_s%0d", tag, s), cap_seg5,
                  (d5 == 4) ? 8'h6F : 8'h3F);
            check($sformatf("%s_idx5_s%0d", tag, s), cap_idx5, d5);
        end
    endtask

    initial begin
        repeat (3) @(posedge cp);
        #1;
        check("rst_bit", led_bit, 4'hF);
        check("rst_seg", led_seg, 8'h00);
        check("rst_idx", scan_idx, 2'd0);
        check("rst_bit5", led_bit5, 5'h1F);
        rst = 1'b0;
        cyc = 0;

        wr(2'd0, 4'd1, 1'b0);
        wr(2'd1, 4'd2, 1'b1);
        wr(2'd2, 4'd3, 1'b0);
        wr(2'd3, 4'd4, 1'b0);
        wr5(3'd5, 4'd8);
        wr5(3'd6, 4'd8);
        wr5(3'd7, 4'd8);
        wr5(3'd4, 4'd9);
        bright = 4'd15;
        disp_en = 1'b1;
        align();
        exp_seg = '{8'h06, 8'hDB, 8'h4F, 8'h66};
        exp_on = 31;
        chk5 = 1'b1;
        repeat (5) slot_chk("scan");
        chk5 = 1'b0;

        bright = 4'd3;
        exp_on = 7;
        repeat (4) slot_chk("br3");
        bright = 4'd0;
        exp_on = 1;
        repeat (4) slot_chk("br0");
        disp_en = 1'b0;
        exp_on = 0;
        repeat (2) slot_chk("off");
        disp_en = 1'b1;
        bright = 4'd15;
        exp_on = 31;

        wr(2'd3, 4'd0, 1'b1);
        wr(2'd2, 4'd0, 1'b0);
        wr(2'd1, 4'd7, 1'b0);
        wr(2'd0, 4'd0, 1'b0);
        lzs_en = 1'b1;
        align();
        exp_seg = '{8'h3F, 8'h07, 8'h00, 8'h80};
        repeat (4) slot_chk("lzs");
        lzs_en = 1'b0;
        exp_seg = '{8'h3F, 8'h07, 8'h3F, 8'hBF};
        repeat (4) slot_chk("nolzs");

        wr(2'd0, 4'd8, 1'b1);
        wr(2'd1, 4'd2, 1'b0);
        wr(2'd2, 4'd3, 1'b0);
        wr(2'd3, 4'd4, 1'b0);
        blink_mask = 4'b0101;
        align();
        exp_seg = '{8'hFF, 8'h5B, 8'h00, 8'h66};
        repeat (4) slot_chk("blk_a");
        blink_mask = 4'b1000;
        exp_seg = '{8'hFF, 8'h5B, 8'h4F, 8'h00};
        repeat (4) slot_chk("blk_b");
        blink_mask = 4'b0000;

        align();
        while ((cyc / 32) % 4 != 0) repeat (32) tick();
        repeat (6) tick();
        check("wr_pre", led_seg, 8'hFF);
        wr(2'd0, 4'd5, 1'b0);
        check("wr_edge", led_seg, 8'hFF);
        tick();
        check("wr_next", led_seg, 8'h6D);
        check("wr_bit", led_bit, 4'b1110);

        align();
        while ((cyc / 32) % 4 != 2) repeat (32) tick();
        repeat (10) tick();
        check("mid_idx", scan_idx, 2'd2);
        check("mid_bit", led_bit, 4'b1011);
        rst = 1'b1;
        @(posedge cp);
        #1;
        check("mid_rst_bit", led_bit, 4'hF);
        check("mid_rst_seg", led_seg, 8'h00);
        check("mid_rst_idx", scan_idx, 2'd0);
        rst = 1'b0;
        cyc = 0;
        exp_seg = '{8'h3F, 8'h3F, 8'h3F, 8'h3F};
        exp_on = 31;
        repeat (4) slot_chk("post");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
